// File: rtl/ide_pio_ctrl.sv
// PIO-mode ATA/IDE bus sequencer: turns one register request into a timed
// setup / strobe / hold cycle on the IDE pins and returns read data with an ack.
module ide_pio_ctrl #(
  parameter int unsigned T_SETUP = 3,
  parameter int unsigned T_PULSE = 8,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned CW      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  inout  wire  [15:0] ide_data_bus,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_we;
  logic [4:0]    r_addr;
  logic [15:0]   r_wdata;
  logic [15:0]   r_rdata;
  logic          r_dior, r_diow, r_oe, r_ack, r_busy;
  logic [1:0]    r_cs;
  logic [2:0]    r_da;

  logic          w_accept, w_we_lat, w_active_nxt, w_capture;
  logic [4:0]    w_addr_lat;
  logic          w_dior_nxt, w_diow_nxt, w_oe_nxt, w_ack_nxt, w_busy_nxt;
  logic [1:0]    w_cs_nxt;
  logic [2:0]    w_da_nxt;

  assign w_accept   = (r_state == S_IDLE) && req;
  // Pins are registered from the next state, so the request fields must be
  // taken from the live inputs on the accepting edge.
  assign w_we_lat   = w_accept ? we   : r_we;
  assign w_addr_lat = w_accept ? addr : r_addr;
  assign w_capture  = (r_state == S_PULSE) && (r_cnt == '0) && !r_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: if (req) begin
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = CW'(T_SETUP - 1);
      end
      S_SETUP: if (r_cnt == '0) begin
        w_state_nxt = S_PULSE;
        w_cnt_nxt   = CW'(T_PULSE - 1);
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
      S_PULSE: if (r_cnt == '0) begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = CW'(T_HOLD - 1);
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
      S_HOLD: if (r_cnt == '0) begin
        w_state_nxt = S_DONE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_active_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_PULSE) ||
                   (w_state_nxt == S_HOLD);
    w_dior_nxt   = !((w_state_nxt == S_PULSE) && !w_we_lat);
    w_diow_nxt   = !((w_state_nxt == S_PULSE) &&  w_we_lat);
    w_oe_nxt     = w_active_nxt && w_we_lat;
    w_cs_nxt     = w_active_nxt ? ~w_addr_lat[4:3] : 2'b11;
    w_da_nxt     = w_active_nxt ? w_addr_lat[2:0] : '0;
    w_ack_nxt    = (w_state_nxt == S_DONE);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dior  <= 1'b1;
      r_diow  <= 1'b1;
      r_oe    <= 1'b0;
      r_cs    <= 2'b11;
      r_da    <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_dior <= w_dior_nxt;
      r_diow <= w_diow_nxt;
      r_oe   <= w_oe_nxt;
      r_cs   <= w_cs_nxt;
      r_da   <= w_da_nxt;
      r_ack  <= w_ack_nxt;
      r_busy <= w_busy_nxt;
      if (w_capture) r_rdata <= ide_data_bus;
    end
  end

  assign ide_data_bus = r_oe ? r_wdata : 'z;
  assign ide_dior     = r_dior;
  assign ide_diow     = r_diow;
  assign ide_cs       = r_cs;
  assign ide_da       = r_da;
  assign rdata        = r_rdata;
  assign ack          = r_ack;
  assign busy         = r_busy;

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// Bench for ide_pio_ctrl: two instances (default timing and 1/1/1 timing), a
// phase-arithmetic reference model, a table of register transactions, and corner sequences.
`timescale 1ns/1ps
module tb_ide_pio_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        req_v[2], we_v[2];
  logic [4:0]  addr_v[2];
  logic [15:0] wdata_v[2];
  logic        dev_en[2];
  logic [15:0] dev_data[2];

  logic [15:0] rdata0, rdata1;
  logic        ack0, ack1, busy0, busy1, dior0, dior1, diow0, diow1;
  logic [1:0]  cs0, cs1;
  logic [2:0]  da0, da1;
  wire  [15:0] bus0, bus1;

  // The device side parks known data on the bus whenever the DUT should not drive it.
  assign bus0 = dev_en[0] ? dev_data[0] : 'z;
  assign bus1 = dev_en[1] ? dev_data[1] : 'z;

  ide_pio_ctrl u_dut0 (
    .clk(clk), .reset_n(reset_n), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .rdata(rdata0), .ack(ack0), .busy(busy0), .ide_data_bus(bus0),
    .ide_dior(dior0), .ide_diow(diow0), .ide_cs(cs0), .ide_da(da0)
  );

  ide_pio_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .CW(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .rdata(rdata1), .ack(ack1), .busy(busy1), .ide_data_bus(bus1),
    .ide_dior(dior1), .ide_diow(diow1), .ide_cs(cs1), .ide_da(da1)
  );

  typedef struct {
    logic ack, busy, dior, diow;
    logic [1:0] cs;
    logic [2:0] da;
    logic [15:0] rdata, bus;
  } outs_t;

  typedef struct {
    logic we; logic [4:0] addr; logic [15:0] wdata; logic [15:0] dev;
    logic [1:0] cs; logic [2:0] da; int lat; int low; logic [15:0] rd;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit          m_act[2];
  int          m_st[2];
  logic        m_we[2];
  logic [4:0]  m_addr[2];
  logic [15:0] m_wd[2], m_rd[2];

  function automatic int ts(int d);  return (d == 0) ? 3 : 1; endfunction
  function automatic int tpw(int d); return (d == 0) ? 8 : 1; endfunction
  function automatic int th(int d);  return (d == 0) ? 2 : 1; endfunction
  function automatic int tsum(int d); return ts(d) + tpw(d) + th(d); endfunction

  // 0 idle, 1 setup, 2 pulse, 3 hold, 4 done -- from cycles elapsed since acceptance
  function automatic int phase(int d);
    int t;
    if (!m_act[d]) return 0;
    t = cyc - m_st[d];
    if (t < ts(d)) return 1;
    if (t < ts(d) + tpw(d)) return 2;
    if (t < tsum(d)) return 3;
    if (t == tsum(d)) return 4;
    return 0;
  endfunction

  function automatic logic exp_oe(int d);
    int p = phase(d);
    return (p >= 1) && (p <= 3) && m_we[d];
  endfunction

  function automatic outs_t get_outs(int d);
    outs_t o;
    if (d == 0) begin
      o.ack = ack0; o.busy = busy0; o.dior = dior0; o.diow = diow0;
      o.cs = cs0; o.da = da0; o.rdata = rdata0; o.bus = bus0;
    end else begin
      o.ack = ack1; o.busy = busy1; o.dior = dior1; o.diow = diow1;
      o.cs = cs1; o.da = da1; o.rdata = rdata1; o.bus = bus1;
    end
    return o;
  endfunction

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic mcheck(input int d);
    outs_t o;
    int p;
    logic act, oe;
    logic [1:0] ecs;
    logic [15:0] ebus;
    o   = get_outs(d);
    p   = phase(d);
    act = (p >= 1) && (p <= 3);
    oe  = act && m_we[d];
    ecs = act ? ~m_addr[d][4:3] : 2'b11;
    ebus = oe ? m_wd[d] : dev_data[d];
    chk(d, "ack",   o.ack,  p == 4);
    chk(d, "busy",  o.busy, p != 0);
    chk(d, "dior",  o.dior, !(p == 2 && !m_we[d]));
    chk(d, "diow",  o.diow, !(p == 2 && m_we[d]));
    chk(d, "cs",    o.cs,   ecs);
    if (act) chk(d, "da", o.da, m_addr[d][2:0]);
    chk(d, "rdata", o.rdata, m_rd[d]);
    chk(d, "bus",   o.bus,   ebus);
  endtask

  task automatic step();
    logic pr[2], pw[2];
    logic [4:0] pa[2];
    logic [15:0] pwd[2], pdv[2];
    logic prst;
    int tprev;
    for (int d = 0; d < 2; d++) begin
      pr[d] = req_v[d]; pw[d] = we_v[d]; pa[d] = addr_v[d];
      pwd[d] = wdata_v[d]; pdv[d] = dev_data[d];
    end
    prst = reset_n;
    @(posedge clk); #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!prst) begin
        m_act[d] = 1'b0;
        m_rd[d]  = '0;
      end else begin
        tprev = cyc - 1 - m_st[d];
        if (m_act[d] && tprev == ts(d) + tpw(d) - 1 && !m_we[d]) m_rd[d] = pdv[d];
        if ((!m_act[d] || tprev > tsum(d)) && pr[d]) begin
          m_act[d] = 1'b1; m_st[d] = cyc;
          m_we[d] = pw[d]; m_addr[d] = pa[d]; m_wd[d] = pwd[d];
        end else if (m_act[d] && (cyc - m_st[d]) > tsum(d)) begin
          m_act[d] = 1'b0;
        end
      end
      dev_en[d] = !exp_oe(d);
    end
    #1;
    for (int d = 0; d < 2; d++) mcheck(d);
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_rd[d] = '0; dev_en[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < 2; d++) mcheck(d);
  endtask

  task automatic run_txn(input int d, input logic w, input logic [4:0] a, input logic [15:0] wd,
                         output int lat, output int low, output logic [1:0] cs_s,
                         output logic [2:0] da_s, output logic [15:0] rd_s);
    outs_t o;
    req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
    lat = -1; low = 0; cs_s = 2'b11; da_s = '0; rd_s = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      req_v[d] = 1'b0;
      o = get_outs(d);
      if ((w ? o.diow : o.dior) == 1'b0) begin
        low++; cs_s = o.cs; da_s = o.da;
      end
      if (o.ack) begin
        lat = n; rd_s = o.rdata;
        break;
      end
    end
    step();
  endtask

  vec_t tbl[5];
  int lat, low, acks, first, second;
  logic [1:0] cs_s;
  logic [2:0] da_s;
  logic [15:0] rd_s;

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 5'b01_111, 16'h00EC, 16'h0000, 2'b10, 3'd7, 14, 8, 16'h0000};
    tbl[1] = '{1'b0, 5'b01_111, 16'h0000, 16'h0058, 2'b10, 3'd7, 14, 8, 16'h0058};
    tbl[2] = '{1'b1, 5'b10_110, 16'h0004, 16'h0000, 2'b01, 3'd6, 14, 8, 16'h0058};
    tbl[3] = '{1'b0, 5'b00_010, 16'h0000, 16'h1234, 2'b11, 3'd2, 14, 8, 16'h1234};
    tbl[4] = '{1'b1, 5'b11_001, 16'hBEEF, 16'h0000, 2'b00, 3'd1, 14, 8, 16'h1234};

    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0;
      dev_en[d] = 1'b1; dev_data[d] = '0;
      m_act[d] = 1'b0; m_st[d] = 0; m_we[d] = 1'b0; m_addr[d] = '0; m_wd[d] = '0; m_rd[d] = '0;
    end
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) mcheck(d);
    step(); step();
    reset_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      dev_data[0] = tbl[i].dev;
      run_txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, low, cs_s, da_s, rd_s);
      chk(0, "tbl_latency", lat, tbl[i].lat);
      chk(0, "tbl_strobe_len", low, tbl[i].low);
      chk(0, "tbl_cs", cs_s, tbl[i].cs);
      chk(0, "tbl_da", da_s, tbl[i].da);
      chk(0, "tbl_rdata", rd_s, tbl[i].rd);
    end
    dev_data[0] = '0;

    // extra req pulses during PULSE and HOLD are ignored
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 5'b01_000; wdata_v[0] = 16'h1234;
    acks = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      req_v[0] = (n == 5) || (n == 6) || (n == 11) || (n == 12);
      if (ack0) acks++;
    end
    chk(0, "ignored_req_acks", acks, 1);

    // req held high re-triggers every 15 cycles
    req_v[0] = 1'b1; first = -1; second = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (ack0) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
    end
    req_v[0] = 1'b0;
    chk(0, "held_req_spacing", second - first, 15);
    for (int n = 0; n < 20; n++) step();

    // device data changes on the last PULSE cycle
    dev_data[0] = 16'h1111;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 5'b01_000;
    rd_s = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      req_v[0] = 1'b0;
      if (n == 11) dev_data[0] = 16'h2222;
      if (ack0) begin
        rd_s = rdata0;
        break;
      end
    end
    step();
    chk(0, "late_change_rdata", rd_s, 16'h2222);
    dev_data[0] = 16'h0000;
    run_txn(0, 1'b1, 5'b01_010, 16'h5A5A, lat, low, cs_s, da_s, rd_s);
    chk(0, "rdata_kept_over_write", rd_s, 16'h2222);

    // reset mid-PULSE of a write, then a full cycle
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 5'b01_111; wdata_v[0] = 16'hC3C3;
    for (int n = 1; n <= 6; n++) begin
      step();
      req_v[0] = 1'b0;
    end
    chk(0, "pre_reset_diow", diow0, 1'b0);
    async_reset();
    step();
    reset_n = 1'b1;
    step();
    run_txn(0, 1'b1, 5'b01_111, 16'h00EC, lat, low, cs_s, da_s, rd_s);
    chk(0, "post_reset_latency", lat, 14);
    chk(0, "post_reset_strobe_len", low, 8);

    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 5'b01_011; wdata_v[1] = 16'h0F0F;
    for (int n = 1; n <= 2; n++) begin
      step();
      req_v[1] = 1'b0;
    end
    chk(1, "pre_reset_diow", diow1, 1'b0);
    async_reset();
    step();
    reset_n = 1'b1;
    step();
    run_txn(1, 1'b1, 5'b01_011, 16'h0F0F, lat, low, cs_s, da_s, rd_s);
    chk(1, "short_latency", lat, 4);
    chk(1, "short_strobe_len", low, 1);
    chk(1, "short_cs", cs_s, 2'b10);

    // randomized traffic on both instances against the model
    for (int n = 0; n < 500; n++) begin
      if (!reset_n) reset_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
        req_v[d]    = ($urandom_range(0, 3) == 0);
        we_v[d]     = $urandom_range(0, 1) == 1;
        addr_v[d]   = 5'($urandom_range(0, 31));
        wdata_v[d]  = 16'($urandom);
        dev_data[d] = 16'($urandom);
      end
      if ($urandom_range(0, 149) == 0) async_reset();
      step();
    end
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) req_v[d] = 1'b0;
    for (int n = 0; n < 20; n++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
